// File: rtl/demux1x4_frame.sv
// rtl/demux1x4_frame.sv - registered 1-to-4 demultiplexer with addressed and round-robin frame modes
//
// Optional feature macro: DEMUX_SHADOW_EN
//   defined   : frame-mode words for A-C are staged in shadow registers and all
//               four outputs are committed together on the slot-3 write.
//   undefined : every frame-mode word goes straight to its channel output.
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     synchronous active-low reset
//   din         input data word (WIDTH bits)
//   din_valid   qualifies din; consumed every cycle it is high
//   select      destination channel in addressed mode (0=A .. 3=D)
//   mode        0 = addressed, 1 = frame (round-robin A->B->C->D)
//   A, B, C, D  registered channel outputs, hold until rewritten
//   out_valid   one-cycle write strobe per channel (bit 0 = A .. bit 3 = D)
//   slot        frame-mode index of the channel the next valid word fills
//   frame_done  one-cycle pulse when a full A-D frame completes
//   frame_cnt   completed frame count, modulo 256

module demux1x4_frame #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic [1:0]       select,
    input  logic             mode,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] D,
    output logic [3:0]       out_valid,
    output logic [1:0]       slot,
    output logic             frame_done,
    output logic [7:0]       frame_cnt
);

    typedef enum logic {IDLE, FILL} state_t;

    state_t           state, state_nxt;
    logic             mode_q;
    logic [WIDTH-1:0] a_nxt, b_nxt, c_nxt, d_nxt;
    logic [3:0]       out_valid_nxt;
    logic [1:0]       slot_nxt;
    logic             frame_done_nxt;
    logic [7:0]       frame_cnt_nxt;

    // A change of mode relative to the previous cycle aborts any partial
    // frame; the word of this cycle is then handled from a clean IDLE/slot 0.
    logic             abort;
    state_t           cur_state;
    logic [1:0]       cur_slot;
    logic [1:0]       wr_slot;

`ifdef DEMUX_SHADOW_EN
    logic [WIDTH-1:0] sh_a, sh_b, sh_c;
    logic [WIDTH-1:0] sh_a_nxt, sh_b_nxt, sh_c_nxt;
`endif

    always_comb begin
        a_nxt          = A;
        b_nxt          = B;
        c_nxt          = C;
        d_nxt          = D;
        out_valid_nxt  = 4'b0000;
        frame_done_nxt = 1'b0;
        frame_cnt_nxt  = frame_cnt;
        abort          = (mode != mode_q);
        cur_state      = abort ? IDLE : state;
        cur_slot       = abort ? 2'd0 : slot;
        wr_slot        = (cur_state == IDLE) ? 2'd0 : cur_slot;
        state_nxt      = cur_state;
        slot_nxt       = cur_slot;
`ifdef DEMUX_SHADOW_EN
        sh_a_nxt       = abort ? '0 : sh_a;
        sh_b_nxt       = abort ? '0 : sh_b;
        sh_c_nxt       = abort ? '0 : sh_c;
`endif

        if (!mode) begin
            state_nxt = IDLE;
            slot_nxt  = 2'd0;
            if (din_valid) begin
                out_valid_nxt[select] = 1'b1;
                case (select)
                    2'd0:    a_nxt = din;
                    2'd1:    b_nxt = din;
                    2'd2:    c_nxt = din;
                    default: d_nxt = din;
                endcase
            end
        end else if (din_valid) begin
            if (wr_slot == 2'd3) begin
                d_nxt          = din;
                frame_done_nxt = 1'b1;
                frame_cnt_nxt  = frame_cnt + 8'd1;
                slot_nxt       = 2'd0;
                state_nxt      = IDLE;
`ifdef DEMUX_SHADOW_EN
                a_nxt          = sh_a;
                b_nxt          = sh_b;
                c_nxt          = sh_c;
                out_valid_nxt  = 4'b1111;
`else
                out_valid_nxt  = 4'b1000;
`endif
            end else begin
                slot_nxt  = wr_slot + 2'd1;
                state_nxt = FILL;
`ifdef DEMUX_SHADOW_EN
                case (wr_slot)
                    2'd0:    sh_a_nxt = din;
                    2'd1:    sh_b_nxt = din;
                    default: sh_c_nxt = din;
                endcase
`else
                out_valid_nxt[wr_slot] = 1'b1;
                case (wr_slot)
                    2'd0:    a_nxt = din;
                    2'd1:    b_nxt = din;
                    default: c_nxt = din;
                endcase
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            mode_q     <= 1'b0;
            A          <= '0;
            B          <= '0;
            C          <= '0;
            D          <= '0;
            out_valid  <= 4'b0000;
            slot       <= 2'd0;
            frame_done <= 1'b0;
            frame_cnt  <= 8'd0;
`ifdef DEMUX_SHADOW_EN
            sh_a       <= '0;
            sh_b       <= '0;
            sh_c       <= '0;
`endif
        end else begin
            state      <= state_nxt;
            mode_q     <= mode;
            A          <= a_nxt;
            B          <= b_nxt;
            C          <= c_nxt;
            D          <= d_nxt;
            out_valid  <= out_valid_nxt;
            slot       <= slot_nxt;
            frame_done <= frame_done_nxt;
            frame_cnt  <= frame_cnt_nxt;
`ifdef DEMUX_SHADOW_EN
            sh_a       <= sh_a_nxt;
            sh_b       <= sh_b_nxt;
            sh_c       <= sh_c_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_demux1x4_frame.sv
// tb/tb_demux1x4_frame.sv - scoreboard testbench for demux1x4_frame

module tb_demux1x4_frame;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] din;
    logic       din_valid;
    logic [1:0] select;
    logic       mode;
    logic [3:0] a_o, b_o, c_o, d_o;
    logic [3:0] out_valid;
    logic [1:0] slot;
    logic       frame_done;
    logic [7:0] frame_cnt;

    demux1x4_frame #(.WIDTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid),
        .select(select), .mode(mode), .A(a_o), .B(b_o), .C(c_o), .D(d_o),
        .out_valid(out_valid), .slot(slot), .frame_done(frame_done),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ch [4];
        logic [3:0] v;
        logic [1:0] s;
        logic       fd;
        logic [7:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   dut_done_seen = 0;

    // Reference model: channel contents, the words of the frame in progress,
    // completed-frame count and the mode seen on the previous cycle.
    logic [3:0] m_ch [4];
    logic [3:0] m_part[$];
    int         m_cnt = 0;
    int         m_done_total = 0;
    logic       m_prev_mode = 1'b0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic step(input logic rst_n, input logic dv, input logic [1:0] sel,
                        input logic md, input logic [3:0] d);
        exp_t e;
        @(negedge clk);
        reset_n = rst_n; din_valid = dv; select = sel; mode = md; din = d;
        e.v  = 4'b0000;
        e.fd = 1'b0;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_ch[i] = 4'd0;
            m_part.delete();
            m_cnt = 0;
            m_prev_mode = 1'b0;
        end else begin
            if (md != m_prev_mode) m_part.delete();
            m_prev_mode = md;
            if (dv) begin
                if (!md) begin
                    m_ch[sel] = d;
                    e.v[sel] = 1'b1;
                end else begin
                    m_part.push_back(d);
`ifndef DEMUX_SHADOW_EN
                    m_ch[m_part.size()-1] = d;
                    e.v[m_part.size()-1] = 1'b1;
`endif
                    if (m_part.size() == 4) begin
`ifdef DEMUX_SHADOW_EN
                        for (int i = 0; i < 4; i++) m_ch[i] = m_part[i];
                        e.v = 4'b1111;
`endif
                        e.fd = 1'b1;
                        m_cnt = (m_cnt + 1) % 256;
                        m_done_total++;
                        m_part.delete();
                    end
                end
            end
        end
        for (int i = 0; i < 4; i++) e.ch[i] = m_ch[i];
        e.s  = md ? 2'(m_part.size()) : 2'd0;
        e.fc = 8'(m_cnt);
        exp_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("A", a_o, e.ch[0]);
                chk("B", b_o, e.ch[1]);
                chk("C", c_o, e.ch[2]);
                chk("D", d_o, e.ch[3]);
                chk("out_valid", out_valid, e.v);
                chk("slot", slot, e.s);
                chk("frame_done", frame_done, e.fd);
                chk("frame_cnt", frame_cnt, e.fc);
                if (frame_done === 1'b1) dut_done_seen++;
            end
        end
    end

    initial begin
        logic [3:0] seq [8];
        logic       md;
        seq = '{4'd0, 4'd5, 4'd10, 4'd15, 4'd1, 4'd2, 4'd3, 4'd4};
        reset_n = 1'b0; din_valid = 1'b0; select = 2'd0; mode = 1'b0; din = 4'd0;

        // Reset with active input
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'd0, 1'b0, 4'hF);

        // Addressed mode
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 2'(i), 1'b0, 4'(i * 5));
        step(1'b1, 1'b0, 2'd0, 1'b0, 4'd0);

        // Frame mode, back to back
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 2'd0, 1'b1, seq[i]);
        step(1'b1, 1'b0, 2'd0, 1'b1, 4'd0);

        // Gaps between words 2 and 3
        step(1'b0, 1'b0, 2'd0, 1'b0, 4'd0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 2'd0, 1'b1, seq[i]);
            if (i == 1) for (int g = 0; g < 3; g++) step(1'b1, 1'b0, 2'd0, 1'b1, 4'd6);
        end

        // Abort by mode change
        step(1'b0, 1'b0, 2'd0, 1'b0, 4'd0);
        step(1'b1, 1'b1, 2'd0, 1'b1, 4'd7);
        step(1'b1, 1'b1, 2'd0, 1'b1, 4'd8);
        step(1'b1, 1'b1, 2'd3, 1'b0, 4'd9);
        step(1'b1, 1'b0, 2'd0, 1'b0, 4'd0);

        // 256+ frames to wrap the frame counter
        step(1'b0, 1'b0, 2'd0, 1'b0, 4'd0);
        for (int i = 0; i < 1028; i++) step(1'b1, 1'b1, 2'd0, 1'b1, 4'($urandom_range(0, 15)));

        // Randomized traffic with mode switches, gaps and occasional reset
        md = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) md = ~md;
            step(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), md, 4'($urandom_range(0, 15)));
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #5;
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("frame_done_total", dut_done_seen, m_done_total);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux1x4_frame.md
# demux1x4_frame

Registered 1-to-4 demultiplexer that distributes a single WIDTH-bit input stream onto four output channels A, B, C and D. It is the receive-side counterpart of the 4x1 multiplexer. It runs in one of two modes:
- Addressed mode: `select` picks the destination channel for each word.
- Frame mode: words fill A→B→C→D in round-robin order, with frame-completion signalling.

It sits downstream of a time-multiplexed bus and hands parallel words to consumer logic.

## Interface
- `WIDTH`, default 4: data width of the input and of each output channel.
- `clk`  input  1  system clock; all state updates on its rising edge.
- `reset_n`  input  1  synchronous, active-low reset.
- `din`  input  WIDTH  input data word.
- `din_valid`  input  1  qualifies `din`; the word is consumed on every cycle where this is high.
- `select`  input  2  destination channel in addressed mode (0=A, 1=B, 2=C, 3=D); ignored in frame mode.
- `mode`  input  1  0 = addressed, 1 = frame (round-robin).
- `A`, `B`, `C`, `D`  output  WIDTH each  registered channel outputs; each holds its value until rewritten.
- `out_valid`  output  4  one-cycle strobe per channel: bit 0 = A … bit 3 = D.
- `slot`  output  2  frame-mode write index, i.e. the channel that the next valid word fills.
- `frame_done`  output  1  one-cycle pulse when a full A–D frame completes.
- `frame_cnt`  output  8  count of completed frames; wraps from 255 to 0.

## Operation
**Reset** (`reset_n` = 0 at a clock edge):
- `A`–`D` = 0, `out_valid` = 0, `slot` = 0, `frame_done` = 0, `frame_cnt` = 0.
- Shadow registers = 0; state = IDLE.
- Reset overrides every other input in the same cycle, including a mid-frame `din_valid`.

**Addressed mode** (`mode` = 0):
- On `din_valid`, `din` is written to the channel chosen by `select`, and `out_valid[select]` strobes.
- `slot` and the state machine are held at 0 / IDLE.
- `frame_done` never asserts.

**Frame mode** (`mode` = 1), state machine IDLE, FILL:
- IDLE: `slot` = 0. A valid word is written to slot 0 (A) → FILL, `slot` = 1.
- FILL: each valid word is written to channel `slot`, then `slot` increments.
- The write to slot 3 (D) completes the frame:
  - `frame_done` pulses;
  - `frame_cnt` increments;
  - `slot` wraps to 0 and the state returns to IDLE.
- Cycles with `din_valid` = 0 hold all state; there is no timeout.
- `out_valid` strobes are described under Configuration.

**Mode change:**
- Any change of `mode` between consecutive cycles aborts a partial frame: `slot` → 0, state → IDLE, and shadow contents are discarded.
- The word presented in the cycle of the change is processed under the new mode.
- Outputs already committed keep their values.

**Arithmetic:**
- `slot` is a 2-bit counter; its wrap from 3 to 0 is explicit.
- `frame_cnt` is modulo 256.

## Timing
- All outputs are registered. A word sampled at edge N appears on its channel output after edge N, together with its `out_valid` strobe.
- Sustained throughput is one word per cycle; back-to-back frames need no idle cycle.
- `frame_done` asserts in the same cycle that D (or the commit; see Configuration) becomes visible, and lasts exactly one cycle.
- `out_valid` bits deassert on the following cycle unless a new write occurs.

## Configuration
Macro `DEMUX_SHADOW_EN`:
- **Defined:** frame mode writes A–C into shadow registers and leaves outputs `A`–`C` unchanged.
  - On the slot-3 write, all four outputs update in the same cycle, so the frame is presented coherently.
  - `out_valid` = 4'b1111 for one cycle, coincident with `frame_done`.
  - An aborted partial frame never reaches the outputs.
  - Addressed mode is unaffected.
- **Undefined:** there are no shadow registers, and each frame-mode word goes straight to its output.
  - `out_valid` strobes per word.
  - A partial frame that is aborted leaves the words already written visible on their outputs.

## Test plan
1. **Reset:** drive `din` = 4'hF with `din_valid` = 1 while `reset_n` = 0 for 3 cycles.
   - Expect all outputs 0, `out_valid` = 0, `frame_cnt` = 0.
2. **Addressed mode:** `mode` = 0; write 0 with `select` = 0, 5 with `select` = 1, 10 with `select` = 2, 15 with `select` = 3 on consecutive cycles.
   - Expect A=0, B=5, C=10, D=15.
   - Expect `out_valid` = 0001, 0010, 0100, 1000 on successive cycles.
   - Expect `frame_done` never high.
3. **Frame mode, back-to-back:** `mode` = 1; stream 0, 5, 10, 15, 1, 2, 3, 4 with `din_valid` held high.
   - Expect `frame_done` high twice, 4 cycles apart.
   - Expect `frame_cnt` = 2 and final A–D = 1, 2, 3, 4.
   - With shadow: A–C stay 0/5/10 until the second commit.
4. **Gaps:** same as scenario 3, with `din_valid` low for 3 cycles between words 2 and 3.
   - Expect `slot` held at 2 during the gap, correct frame completion, and `frame_cnt` = 1 after the first frame.
5. **Abort:** in frame mode send 7, 8; switch to `mode` = 0, `select` = 3, `din` = 9.
   - Expect D = 9 and `slot` = 0.
   - With shadow: A = B = 0 (prior values).
   - Without shadow: A = 7, B = 8.
6. **Wrap:** complete 256 frames.
   - Expect `frame_cnt` to wrap to 0 and `frame_done` to keep pulsing once per frame.
